// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs feeding CDB_LANES registered broadcast lanes.
// Define CDB_ARB_STATS_EN to add the stat_broadcasts / stat_stalls counters.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 7
`endif

// Generic FIFO with flush; head is read combinationally from storage.
// Latency: a push is visible at the head one edge later.
// Backpressure: a push while full is only taken when the same cycle pops.
module cdb_arb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// Round-robin selection of up to CDB_LANES non-empty source FIFOs per cycle.
// Latency: accepted at edge E0, broadcast after edge E1, held one cycle.
// Backpressure: src_ready drops when a source FIFO holds FIFO_DEPTH entries.
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int CDB_LANES  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = `ROB_SIZE_WIDTH,
  parameter int PREG_W     = `PHYSICAL_REG_NUM_WIDTH,
  parameter int DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*PREG_W-1:0]   src_preg,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [CDB_LANES-1:0]        cdb_valid,
  output logic [CDB_LANES*TAG_W-1:0]  cdb_tag,
  output logic [CDB_LANES*PREG_W-1:0] cdb_preg,
  output logic [CDB_LANES*DATA_W-1:0] cdb_data
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_broadcasts,
  output logic [31:0]                 stat_stalls
`endif
);
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LCNT_W = $clog2(CDB_LANES + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } entry_t;
  localparam int ENT_W = $bits(entry_t);

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_next;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] grant;
  logic [CNT_W-1:0]   count [NUM_SRC];
  entry_t             head [NUM_SRC];
  logic [CDB_LANES-1:0] lane_hit;
  logic [SRC_W-1:0]   lane_src [CDB_LANES];
  entry_t             lane_ent [CDB_LANES];
  logic [LCNT_W-1:0]  n_grant;
  logic [SRC_W:0]     scan_sum;
  logic [SRC_W-1:0]   scan_idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    entry_t           push_dat;
    logic [ENT_W-1:0] head_raw;

    assign push_dat = {src_tag[i*TAG_W +: TAG_W], src_preg[i*PREG_W +: PREG_W],
                       src_data[i*DATA_W +: DATA_W]};

    cdb_arb_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .push     (src_valid[i]),
      .push_dat (push_dat),
      .pop      (grant[i]),
      .head_dat (head_raw),
      .count    (count[i]),
      .empty    (empty[i])
    );

    assign head[i]      = head_raw;
    assign src_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
  end

  // Scan from rr_ptr; the k-th non-empty source found drives lane k.
  always_comb begin
    grant    = '0;
    lane_hit = '0;
    n_grant  = '0;
    rr_next  = rr_ptr;
    scan_sum = '0;
    scan_idx = '0;
    for (int l = 0; l < CDB_LANES; l++) lane_src[l] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (scan_sum >= (SRC_W+1)'(NUM_SRC)) scan_sum = scan_sum - (SRC_W+1)'(NUM_SRC);
      scan_idx = scan_sum[SRC_W-1:0];
      if (!empty[scan_idx] && (n_grant < LCNT_W'(CDB_LANES))) begin
        grant[scan_idx] = 1'b1;
        for (int l = 0; l < CDB_LANES; l++) begin
          if (n_grant == LCNT_W'(l)) begin
            lane_hit[l] = 1'b1;
            lane_src[l] = scan_idx;
          end
        end
        n_grant = n_grant + 1'b1;
        rr_next = (scan_idx == SRC_W'(NUM_SRC - 1)) ? '0 : scan_idx + SRC_W'(1);
      end
    end
  end

  always_comb begin
    for (int l = 0; l < CDB_LANES; l++) begin
      lane_ent[l] = lane_hit[l] ? head[lane_src[l]] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_preg  <= '0;
      cdb_data  <= '0;
    end else if (flush) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_preg  <= '0;
      cdb_data  <= '0;
    end else begin
      rr_ptr <= rr_next;
      for (int l = 0; l < CDB_LANES; l++) begin
        cdb_valid[l]                  <= lane_hit[l];
        cdb_tag[l*TAG_W +: TAG_W]     <= lane_ent[l].tag;
        cdb_preg[l*PREG_W +: PREG_W]  <= lane_ent[l].preg;
        cdb_data[l*DATA_W +: DATA_W]  <= lane_ent[l].data;
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_broadcasts <= '0;
      stat_stalls     <= '0;
    end else begin
      stat_broadcasts <= stat_broadcasts + 32'($countones(cdb_valid));
      if (|(src_valid & ~src_ready)) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based model, plus literal directed checks.
module tb_cdb_arbiter;
  localparam int NS = 4, NL = 2, DEPTH = 4, TW = 6, PW = 7, DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush;
  logic [NS-1:0]    src_valid, src_ready;
  logic [NS*TW-1:0] src_tag;
  logic [NS*PW-1:0] src_preg;
  logic [NS*DW-1:0] src_data;
  logic [NL-1:0]    cdb_valid;
  logic [NL*TW-1:0] cdb_tag;
  logic [NL*PW-1:0] cdb_preg;
  logic [NL*DW-1:0] cdb_data;
`ifdef CDB_ARB_STATS_EN
  logic [31:0] stat_broadcasts, stat_stalls;
  logic [31:0] m_bc, m_st;
`endif

  int  tests = 0;
  int  fails = 0;
  bit  chk_en = 0;

  cdb_arbiter #(.NUM_SRC(NS), .CDB_LANES(NL), .FIFO_DEPTH(DEPTH),
                .TAG_W(TW), .PREG_W(PW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_preg(src_preg), .src_data(src_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_preg(cdb_preg), .cdb_data(cdb_data)
`ifdef CDB_ARB_STATS_EN
    , .stat_broadcasts(stat_broadcasts), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [PW-1:0] preg;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q [NS][$];
  int            rr;
  logic [NL-1:0] e_vld;
  ent_t          e_out [NL];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) q[s].delete();
    rr = 0;
    e_vld = '0;
    for (int l = 0; l < NL; l++) e_out[l] = '{tag: '0, preg: '0, data: '0};
`ifdef CDB_ARB_STATS_EN
    m_bc = 0;
    m_st = 0;
`endif
  endtask

  // One clock edge of the arbiter, written from the behavioural rules.
  task automatic model_step();
    int   g[$];
    bit   granted [NS];
    bit   was_full [NS];
    ent_t nx [NL];
    logic [NL-1:0] nv;
    for (int s = 0; s < NS; s++) begin
      granted[s]  = 0;
      was_full[s] = (q[s].size() == DEPTH);
    end
`ifdef CDB_ARB_STATS_EN
    m_bc += $countones(e_vld);
    for (int s = 0; s < NS; s++) if (src_valid[s] && was_full[s]) begin m_st++; break; end
`endif
    for (int k = 0; k < NS; k++) begin
      int s = (rr + k) % NS;
      if (q[s].size() > 0 && g.size() < NL) begin
        g.push_back(s);
        granted[s] = 1;
      end
    end
    if (flush) begin
      for (int s = 0; s < NS; s++) q[s].delete();
      e_vld = '0;
      for (int l = 0; l < NL; l++) e_out[l] = '{tag: '0, preg: '0, data: '0};
      return;
    end
    nv = '0;
    for (int l = 0; l < NL; l++) nx[l] = '{tag: '0, preg: '0, data: '0};
    for (int l = 0; l < g.size(); l++) begin
      nx[l] = q[g[l]].pop_front();
      nv[l] = 1'b1;
    end
    if (g.size() > 0) rr = (g[g.size()-1] + 1) % NS;
    for (int s = 0; s < NS; s++) begin
      if (src_valid[s] && (!was_full[s] || granted[s]))
        q[s].push_back('{tag: src_tag[s*TW +: TW], preg: src_preg[s*PW +: PW],
                         data: src_data[s*DW +: DW]});
    end
    e_vld = nv;
    for (int l = 0; l < NL; l++) e_out[l] = nx[l];
  endtask

  always @(negedge reset) model_reset();
  always @(posedge clk) if (reset === 1'b1) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      for (int l = 0; l < NL; l++) begin
        check($sformatf("m_valid%0d", l), cdb_valid[l], e_vld[l]);
        check($sformatf("m_tag%0d", l), cdb_tag[l*TW +: TW], e_out[l].tag);
        check($sformatf("m_preg%0d", l), cdb_preg[l*PW +: PW], e_out[l].preg);
        check($sformatf("m_data%0d", l), cdb_data[l*DW +: DW], e_out[l].data);
      end
      for (int s = 0; s < NS; s++)
        check($sformatf("m_ready%0d", s), src_ready[s], q[s].size() != DEPTH);
`ifdef CDB_ARB_STATS_EN
      check("m_stat_bc", stat_broadcasts, m_bc);
      check("m_stat_st", stat_stalls, m_st);
`endif
    end
  end

  task automatic set_src(int s, logic v, logic [TW-1:0] t, logic [PW-1:0] p, logic [DW-1:0] d);
    src_valid[s]          = v;
    src_tag[s*TW +: TW]   = t;
    src_preg[s*PW +: PW]  = p;
    src_data[s*DW +: DW]  = d;
  endtask

  initial begin
    flush = 0; src_valid = '0; src_tag = '0; src_preg = '0; src_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1;
    check("reset_valid", cdb_valid, 0);
    check("reset_ready", src_ready, 4'hF);
    check("reset_tag", cdb_tag, 0);

    // Single result on source 2.
    set_src(2, 1, 6'd5, 7'd17, 32'hDEAD);
    @(negedge clk);
    check("t1_e0_valid", cdb_valid, 0);
    src_valid = '0;
    @(negedge clk);
    check("t1_valid", cdb_valid, 2'b01);
    check("t1_tag", cdb_tag[TW-1:0], 5);
    check("t1_preg", cdb_preg[PW-1:0], 17);
    check("t1_data", cdb_data[DW-1:0], 32'hDEAD);
    @(negedge clk);
    check("t1_one_cycle", cdb_valid, 0);

    // One result on source 3 brings rr_ptr back to 0.
    set_src(3, 1, 6'd1, 7'd1, 32'd1);
    @(negedge clk);
    src_valid = '0;
    repeat (3) @(negedge clk);

    // All sources stream every cycle.
    for (int c = 0; c < 16; c++) begin
      if (c == 2) begin
        check("t2_c2_vld", cdb_valid, 2'b11);
        check("t2_c2_l0", cdb_tag[0 +: TW], 0);
        check("t2_c2_l1", cdb_tag[TW +: TW], 8);
      end
      if (c == 3) begin
        check("t2_c3_l0", cdb_tag[0 +: TW], 16);
        check("t2_c3_l1", cdb_tag[TW +: TW], 24);
      end
      if (c == 4) begin
        check("t2_c4_l0", cdb_tag[0 +: TW], 1);
        check("t2_c4_l1", cdb_tag[TW +: TW], 9);
      end
      for (int s = 0; s < NS; s++) set_src(s, 1, TW'(s*8 + c), PW'(c), $urandom);
      @(negedge clk);
    end
    check("t2_all_full", src_ready, 4'h0);
    src_valid = '0;
    repeat (10) @(negedge clk);
    check("t2_drained", src_ready, 4'hF);

    // Source 1 alone: tags 1..4 in order on lane 0.
    for (int i = 0; i < 7; i++) begin
      if (i >= 2 && i <= 5) begin
        check("t3_vld", cdb_valid, 2'b01);
        check("t3_tag", cdb_tag[0 +: TW], i - 1);
      end
      if (i == 6) check("t3_idle", cdb_valid, 0);
      if (i < 4) set_src(1, 1, TW'(i + 1), PW'(i), $urandom);
      else src_valid = '0;
      @(negedge clk);
    end

    // Flush with three buffered entries and a concurrent push.
    set_src(0, 1, 6'd40, 7'd1, 32'd1);
    set_src(1, 1, 6'd41, 7'd2, 32'd2);
    set_src(2, 1, 6'd42, 7'd3, 32'd3);
    @(negedge clk);
    flush = 1;
    src_valid = '0;
    set_src(3, 1, 6'd43, 7'd4, 32'd4);
    @(negedge clk);
    check("t5_flush_vld", cdb_valid, 0);
    check("t5_flush_rdy", src_ready, 4'hF);
    flush = 0;
    src_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_stale", cdb_valid, 0);
    end

    // Randomized traffic with occasional flushes and one async reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int s = 0; s < NS; s++)
        set_src(s, $urandom_range(0, 99) < 60, TW'($urandom), PW'($urandom), $urandom);
      flush = ($urandom_range(0, 49) == 0);
      if (cyc == 1500) begin #2 reset = 1'b0; end
      if (cyc == 1502) begin #2 reset = 1'b1; end
      @(negedge clk);
    end
    src_valid = '0;
    flush = 0;
    repeat (12) @(negedge clk);
    check("final_ready", src_ready, 4'hF);
    check("final_idle", cdb_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
